// File: rtl/clock_timer_cfg.sv
// Configurable BCD time-of-day counter: built-in prescaler, 12/24-hour display,
// validated synchronous load and an hh:mm alarm. Time is stored as 24-hour BCD.
module clock_timer_cfg #(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       mode_24h,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  input  logic       ld_pm,
  input  logic       al_en,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick_1s,
  output logic       day_roll,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC) + 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] pre;
  logic [7:0]       h24_q, mm_q, ss_q;

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  // Valid only for 0..23; hours are the only binary->BCD conversion needed.
  function automatic logic [7:0] hour_to_bcd(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (v >= 5'd20) begin
      r = v - 5'd20;
      return {4'd2, r[3:0]};
    end else if (v >= 5'd10) begin
      r = v - 5'd10;
      return {4'd1, r[3:0]};
    end
    return {4'd0, r[3:0]};
  endfunction

  function automatic logic digits_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  // Second-advance with full ripple carry.
  logic       wrap, sec_carry, min_carry;
  logic [7:0] ss_nx, mm_nx, h24_nx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wrap      = ena && (pre == PRE_MAX);
    sec_carry = (ss_q == 8'h59);
    min_carry = sec_carry && (mm_q == 8'h59);
    ss_nx     = sec_carry ? 8'h00 : bcd_inc(ss_q);
    mm_nx     = mm_q;
    h24_nx    = h24_q;
    if (sec_carry) mm_nx  = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
    if (min_carry) h24_nx = (h24_q == 8'h23) ? 8'h00 : bcd_inc(h24_q);
  end

  // Load validation and translation of the requested hour into 24-hour form.
  logic [6:0] ld_hr_bin;
  logic [4:0] ld_h24_bin;
  logic [7:0] ld_h24;
  logic       ld_ok;

  always_comb begin
    ld_hr_bin  = bcd_to_bin(ld_hh);
    ld_ok      = digits_ok(ld_hh) && digits_ok(ld_mm) && digits_ok(ld_ss) &&
                 (ld_mm[7:4] <= 4'd5) && (ld_ss[7:4] <= 4'd5);
    ld_h24_bin = ld_hr_bin[4:0];
    if (mode_24h) begin
      ld_ok = ld_ok && (ld_hr_bin <= 7'd23);
    end else begin
      ld_ok = ld_ok && (ld_hr_bin >= 7'd1) && (ld_hr_bin <= 7'd12);
      if (ld_hr_bin == 7'd12) ld_h24_bin = ld_pm ? 5'd12 : 5'd0;
      else if (ld_pm)         ld_h24_bin = ld_hr_bin[4:0] + 5'd12;
    end
    ld_h24 = hour_to_bcd(ld_h24_bin);
  end

  // Display mapping; purely combinational from the stored 24-hour time.
  logic [4:0] h_bin, h12_bin;

  always_comb begin
    h_bin   = 5'(h24_q[5:4]) * 5'd10 + 5'(h24_q[3:0]);
    h12_bin = h_bin;
    if (h_bin == 5'd0)       h12_bin = 5'd12;
    else if (h_bin > 5'd12)  h12_bin = h_bin - 5'd12;
    hh = mode_24h ? h24_q : hour_to_bcd(h12_bin);
    mm = mm_q;
    ss = ss_q;
    pm = (h_bin >= 5'd12);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      h24_q     <= 8'h00;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      tick_1s   <= 1'b0;
      day_roll  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      tick_1s   <= 1'b0;
      day_roll  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
      if (load && ld_ok) begin
        // A good load wins over a coincident advance and restarts the second.
        h24_q <= ld_h24;
        mm_q  <= ld_mm;
        ss_q  <= ld_ss;
        pre   <= '0;
      end else begin
        load_err <= load;
        if (wrap) begin
          pre       <= '0;
          h24_q     <= h24_nx;
          mm_q      <= mm_nx;
          ss_q      <= ss_nx;
          tick_1s   <= 1'b1;
          day_roll  <= ({h24_nx, mm_nx, ss_nx} == 24'h000000);
          alarm_hit <= al_en && ({h24_nx, mm_nx, ss_nx} == {al_hh, al_mm, 8'h00});
        end else if (ena) begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/clock_timer_cfg.md
Name: clock_timer_cfg

Overview:
- Parametrised successor to the fixed 12-hour BCD clock timer.
- Adds a built-in prescaler, runtime 12/24-hour display mode, synchronous time load with validity checking, and an hh:mm alarm.
- Time is held internally as 24-hour BCD; the display format is derived from it.
- Sits behind the system clock and drives display/RTC logic directly.

Parameters:
- TICKS_PER_SEC, 4, clk cycles per second; must be >= 1. A value of 1 gives one second per enabled cycle.
- PRE_W, $clog2(TICKS_PER_SEC)+1, prescaler counter width (derived; not overridden).

Ports:
- clk  in  1  system clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ena  in  1  count enable; when low, prescaler and time freeze.
- mode_24h  in  1  display mode: 1 = 24-hour hh output, 0 = 12-hour hh output plus pm.
- load  in  1  one-cycle request to load ld_hh/ld_mm/ld_ss/ld_pm.
- ld_hh  in  8  BCD hour to load, in the current mode's format.
- ld_mm  in  8  BCD minute to load.
- ld_ss  in  8  BCD second to load.
- ld_pm  in  1  PM flag for a 12-hour load; ignored in 24-hour mode.
- al_en  in  1  alarm enable.
- al_hh  in  8  BCD alarm hour, always 24-hour format 00-23.
- al_mm  in  8  BCD alarm minute.
- hh  out  8  BCD hour in display format.
- mm  out  8  BCD minute.
- ss  out  8  BCD second.
- pm  out  1  1 when internal hour >= 12, valid in both modes.
- tick_1s  out  1  one-cycle pulse on each second advance.
- day_roll  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 advance.
- alarm_hit  out  1  one-cycle pulse on reaching the alarm time.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Registers: prescaler pre, internal hour h24 (BCD 00-23), minute, second, and the pulse outputs.
- hh/mm/ss/pm are combinational functions of the registers: no added latency.
- Reset (reset_n low, asynchronous):
  - pre=0, h24=00, mm=00, ss=00.
  - tick_1s=0, day_roll=0, alarm_hit=0, load_err=0.
  - Displayed: hh=0x12, pm=0 in 12-hour mode; hh=0x00 in 24-hour mode.
  - Reset release is synchronous to clk; the first count can occur no earlier than TICKS_PER_SEC enabled cycles after release.
- Prescaler:
  - When ena=1: if pre==TICKS_PER_SEC-1, pre->0 and a second-advance occurs; otherwise pre++.
  - When ena=0: pre holds and no advance occurs.
- Second-advance, with ripple carry in the same cycle:
  - ss: x9 -> (x+1)0; 59 -> 00 with carry to mm.
  - mm: 59 -> 00 with carry to h24.
  - h24: 09 -> 10, 19 -> 20, 23 -> 00.
  - BCD digits never take values A-F.
- tick_1s is asserted in the cycle after every advance, i.e. registered alongside the new time.
- day_roll is asserted in the same cycle as tick_1s when the new time is 00:00:00.
- alarm_hit is asserted in the same cycle as tick_1s when al_en=1 and the new time is al_hh:al_mm:00.
  - Loads never fire the alarm.
  - An invalid alarm value (hour > 23 or minute > 59) simply never matches.
- 12-hour display mapping (mode_24h=0):
  - h24 00 -> 12 AM; 01-11 -> same value, AM.
  - h24 12 -> 12 PM; 13-23 -> h24-12, PM.
- Load (load=1 sampled on a rising edge):
  - Validation:
    - Every BCD digit must be <= 9; mm and ss must be <= 59.
    - Hour in 24-hour mode: 00-23.
    - Hour in 12-hour mode: 01-12, with 12 AM -> h24 00, 12 PM -> h24 12, and n PM -> n+12.
  - Valid load: registers take the loaded value and pre->0. No tick_1s, day_roll or alarm_hit that cycle.
  - Invalid load: load_err pulses for one cycle; time and pre are unchanged, and prescaler counting continues normally.
  - A load has priority over a coincident second-advance; that advance is discarded.
  - A load is honoured even when ena=0.
- mode_24h may change at any time. It affects only the display mapping and load interpretation, never the stored time.
- Pulse outputs are deasserted in every cycle not listed above.

Test Plan:
- Reset mid-count: assert reset_n=0 at an arbitrary time -> outputs 12:00:00 AM (hh=0x12, pm=0) immediately; after release with ena=1, first tick_1s arrives 4 cycles later and ss=0x01.
- Carry chain: 24h load 23:59:58 and run 8 enabled cycles -> 23:59:59, then 00:00:00 with day_roll=1 on the tick_1s cycle only.
- 12h mapping: load 12:59:59 PM in 12-hour mode, then one second -> hh=0x01, pm=1; switch mode_24h=1 -> hh=0x13 with no change to mm/ss.
- Invalid loads: load 24h 24:00:00, 12h 00:10:00, ss=0x5A -> each gives one load_err pulse with time unchanged; a load of 11:59:59 PM (12h) is accepted -> hh=0x23 in 24h display.
- Alarm: al_en=1, al=07:30, load 07:29:58 (24h) -> exactly one alarm_hit on the 07:30:00 tick; with al_en=0 -> none; a load of 07:30:00 -> none.
- Enable/priority: ena=0 for 10 cycles -> ss and pre frozen; load asserted in the same cycle as a prescaler wrap -> loaded value held and the next tick comes a full 4 cycles later.
